multiplication_seq_bw: RTL and testbench
========================================

# multiplication_seq_bw

Parametrised sequential multiplier for the operation-composition datapath. It accepts two BW-bit operands on a start strobe and computes the product with a radix-2 shift-add iteration. It returns a BW-bit result with an overflow flag under a level ready handshake. It replaces the fixed 16-bit multiplication operation: it adds width generality, a signed mode and a saturating mode, and keeps the same RST/ST/CLK/RD/RES/IN* port contract so compositions can chain it directly.

## Interface
- BW, 16: operand and result width, 2..64.
- SIGNED, 0: 0 treats operands as unsigned; 1 treats them as two's complement.
- SAT, 0: 0 wraps the result to BW bits; 1 clamps the result to the representable range on overflow.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- ST  in  1  start; sampled on the rising edge of CLK.
- IN0  in  BW  multiplicand.
- IN1  in  BW  multiplier.
- RD  out  1  ready; level signal, high while RES and OVF hold a valid result.
- RES  out  BW  result.
- OVF  out  1  set when the full product does not fit in BW bits for the selected mode.

## Operation
- States: IDLE, RUN, DONE.
- On RST: state goes to IDLE; RD=0, RES=0, OVF=0; internal accumulator, counter and operand registers are cleared.
- Start acceptance:
  - ST=1 at an edge in IDLE or DONE starts a new operation.
  - At that edge: IN0/IN1 are captured, RD goes to 0, the counter is set to BW, the 2·BW-bit accumulator is cleared, and the state becomes RUN.
  - ST is ignored in RUN; IN0/IN1 changes after capture have no effect.
- Operand preparation in SIGNED=1:
  - Each operand is replaced by its magnitude (BW bits unsigned; -2^(BW-1) maps to 2^(BW-1)).
  - The result sign NEG = sign(IN0) XOR sign(IN1) is recorded.
- In SIGNED=0, NEG=0 and the operands are used as-is.
- RUN, one step per edge:
  - If multiplier bit0=1, the accumulator gains the multiplicand (2·BW-bit adder).
  - The multiplicand shifts left by 1; the multiplier shifts right by 1; the counter decrements.
  - When the counter reaches 0, the state goes to DONE.
- Finalisation, at the RUN→DONE edge, with M = unsigned magnitude product (2·BW bits):
  - Unsigned: OVF = |M[2BW-1:BW]. RES = M[BW-1:0], or all-ones if SAT=1 and OVF=1.
  - Signed, NEG=0: OVF = (M > 2^(BW-1)-1). Wrap result = M[BW-1:0]. Saturated result = 2^(BW-1)-1.
  - Signed, NEG=1: OVF = (M > 2^(BW-1)). Wrap result = low BW bits of the negation of M. Saturated result = -2^(BW-1).
  - A zero product gives RES=0 with no negative zero.
  - RD goes to 1.
- DONE: RES, OVF and RD hold until the next accepted ST or RST.
- ST held high continuously restarts at every DONE, so RD is high for exactly one cycle per operation.
- RST asserted mid-RUN aborts the operation immediately (asynchronous); the operation does not resume after RST is released.

## Timing
- Accepting edge = edge k. RUN covers edges k+1..k+BW; the final RUN edge, k+BW, also performs finalisation and moves to DONE.
- RD, RES and OVF become valid after edge k+BW, so latency is BW cycles from the accepting edge (16 cycles at BW=16).
- RD falls after edge k; RES/OVF keep their old values until the finalisation edge.
- Back-to-back operations: ST at the first DONE cycle is accepted, giving a throughput of one result per BW+1 cycles.
- There are no combinational paths from inputs to outputs; all outputs are registered.

## Test plan
- BW=16, SIGNED=0, SAT=0; RST high for 15 ns, ST pulse for one cycle with IN0=4, IN1=5 -> RD rises 16 cycles after the accepting edge, RES=0x0014, OVF=0.
- BW=16, unsigned, IN0=IN1=0xFFFF -> SAT=0: RES=0x0001, OVF=1; SAT=1: RES=0xFFFF, OVF=1.
- BW=16, SIGNED=1, IN0=0xFFFD (-3), IN1=0x0005 -> RES=0xFFF1, OVF=0; IN0=0x8000, IN1=0xFFFF -> SAT=0: RES=0x8000, OVF=1; SAT=1: RES=0x7FFF, OVF=1.
- BW=8, SIGNED=1, SAT=1, IN0=0x80, IN1=0x01 -> RES=0x80, OVF=0 (boundary -128 fits); IN0=IN1=0x80 -> RES=0x7F, OVF=1.
- ST re-pulsed mid-RUN with different operands -> ignored; the first result appears at the original latency. ST held high -> RD is a one-cycle pulse every 17 cycles.
- RST asserted 5 cycles into RUN -> RD=0, RES=0, OVF=0 immediately; after release the block stays IDLE until ST; the next operation 7×9 gives RES=0x003F.

Source files
------------

// File: rtl/multiplication_seq_bw.sv
// Sequential radix-2 shift-add multiplier with optional signed and saturating modes.
// Result and overflow are registered and presented under a level RD handshake.
module multiplication_seq_bw #(
  parameter int BW     = 16,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  input  logic [BW-1:0] IN0,
  input  logic [BW-1:0] IN1,
  output logic          RD,
  output logic [BW-1:0] RES,
  output logic          OVF,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(BW + 1);
  // HALF = 2^(BW-1): largest negative magnitude; POS_MAX = 2^(BW-1)-1.
  localparam logic [2*BW-1:0] HALF    = {{BW{1'b0}}, 1'b1, {(BW-1){1'b0}}};
  localparam logic [2*BW-1:0] POS_MAX = HALF - 1'b1;
  localparam logic [BW-1:0]   MAX_BW  = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0]   MIN_BW  = {1'b1, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [2*BW-1:0] mcand, acc, acc_sum;
  logic [BW-1:0]   mplier, mag0, mag1;
  logic [CW-1:0]   cnt;
  logic            neg, neg_in, last_step;
  logic [BW-1:0]   res_fin;
  logic            ovf_fin;

  assign dbg_state = state;

  // Handshake: RD is a level; RES/OVF are valid exactly while RD=1.
  // A start is accepted only in IDLE or DONE; ST is ignored in RUN.

  always_comb begin
    mag0   = (SIGNED && IN0[BW-1]) ? (~IN0 + BW'(1)) : IN0;
    mag1   = (SIGNED && IN1[BW-1]) ? (~IN1 + BW'(1)) : IN1;
    neg_in = SIGNED && (IN0[BW-1] ^ IN1[BW-1]);
  end

  assign acc_sum   = acc + (mplier[0] ? mcand : '0);
  assign last_step = (cnt == CW'(1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (ST) state_nx = RUN;
      RUN:        if (last_step) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Finalisation works on the product including the last step's addition.
  always_comb begin
    ovf_fin = 1'b0;
    res_fin = acc_sum[BW-1:0];
    if (!SIGNED) begin
      ovf_fin = |acc_sum[2*BW-1:BW];
      if (SAT && ovf_fin) res_fin = '1;
    end else if (!neg) begin
      ovf_fin = (acc_sum > POS_MAX);
      if (SAT && ovf_fin) res_fin = MAX_BW;
    end else begin
      ovf_fin = (acc_sum > HALF);
      res_fin = (SAT && ovf_fin) ? MIN_BW : (~acc_sum[BW-1:0] + BW'(1));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      RD     <= 1'b0;
      RES    <= '0;
      OVF    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ST) begin
            mcand  <= {{BW{1'b0}}, mag0};
            mplier <= mag1;
            acc    <= '0;
            cnt    <= CW'(BW);
            neg    <= neg_in;
            RD     <= 1'b0;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (last_step) begin
            RES <= res_fin;
            OVF <= ovf_fin;
            RD  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplication_seq_bw.sv
// Bench for multiplication_seq_bw: five parameter variants driven in parallel,
// results checked against an arithmetic reference model through expected queues.
module tb_multiplication_seq_bw;

  logic        CLK = 1'b0;
  logic        RST, ST;
  logic [15:0] IN0, IN1;

  logic        rd_w[5];
  logic        ovf_w[5];
  logic [15:0] res_w[4];
  logic [7:0]  res8;
  logic [1:0]  dbg_w[5];

  int bw_t[5]  = '{16, 16, 16, 16, 8};
  bit sg_t[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  bit sat_t[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  logic [16:0] exp_q[5][$];
  int          cyc_q[5][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  multiplication_seq_bw #(.BW(16), .SIGNED(1'b0), .SAT(1'b0)) u_uw (
    .CLK(CLK), .RST(RST), .ST(ST), .IN0(IN0), .IN1(IN1),
    .RD(rd_w[0]), .RES(res_w[0]), .OVF(ovf_w[0]), .dbg_state(dbg_w[0]));
  multiplication_seq_bw #(.BW(16), .SIGNED(1'b0), .SAT(1'b1)) u_us (
    .CLK(CLK), .RST(RST), .ST(ST), .IN0(IN0), .IN1(IN1),
    .RD(rd_w[1]), .RES(res_w[1]), .OVF(ovf_w[1]), .dbg_state(dbg_w[1]));
  multiplication_seq_bw #(.BW(16), .SIGNED(1'b1), .SAT(1'b0)) u_sw (
    .CLK(CLK), .RST(RST), .ST(ST), .IN0(IN0), .IN1(IN1),
    .RD(rd_w[2]), .RES(res_w[2]), .OVF(ovf_w[2]), .dbg_state(dbg_w[2]));
  multiplication_seq_bw #(.BW(16), .SIGNED(1'b1), .SAT(1'b1)) u_ss (
    .CLK(CLK), .RST(RST), .ST(ST), .IN0(IN0), .IN1(IN1),
    .RD(rd_w[3]), .RES(res_w[3]), .OVF(ovf_w[3]), .dbg_state(dbg_w[3]));
  multiplication_seq_bw #(.BW(8), .SIGNED(1'b1), .SAT(1'b1)) u_s8 (
    .CLK(CLK), .RST(RST), .ST(ST), .IN0(IN0[7:0]), .IN1(IN1[7:0]),
    .RD(rd_w[4]), .RES(res8), .OVF(ovf_w[4]), .dbg_state(dbg_w[4]));

  function automatic logic [15:0] res_of(int i);
    logic [15:0] r;
    r = {8'h00, res8};
    for (int k = 0; k < 4; k++) if (k == i) r = res_w[k];
    return r;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [16:0] model(int bw, bit sg, bit sat, logic [15:0] a, logic [15:0] b);
    longint md, ua, ub, p, hi, lo, r;
    logic   ovf;
    md = longint'(1) << bw;
    ua = longint'(a) & (md - 1);
    ub = longint'(b) & (md - 1);
    if (sg) begin
      if (ua >= md / 2) ua = ua - md;
      if (ub >= md / 2) ub = ub - md;
      p   = ua * ub;
      hi  = md / 2 - 1;
      lo  = -(md / 2);
      ovf = (p > hi) || (p < lo);
      r   = p;
      if (sat && ovf) r = (p > hi) ? hi : lo;
    end else begin
      p   = ua * ub;
      ovf = (p >= md);
      r   = p;
      if (sat && ovf) r = md - 1;
    end
    return {ovf, 16'(r & (md - 1))};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(string name, int inst, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h want %0h", name, inst, got, want);
    end
  endtask

  task automatic push_one(int i, logic [15:0] a, logic [15:0] b, int acc_cyc);
    exp_q[i].push_back(model(bw_t[i], sg_t[i], sat_t[i], a, b));
    cyc_q[i].push_back(acc_cyc + bw_t[i]);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 5; i++) n += exp_q[i].size();
    return n;
  endfunction

  // ---------------- monitor ----------------
  logic rd_prev[5];
  initial begin
    logic [16:0] e;
    int          ec;
    for (int i = 0; i < 5; i++) rd_prev[i] = 1'b0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 5; i++) begin
        if (rd_w[i] === 1'b1 && rd_prev[i] !== 1'b1) begin
          if (exp_q[i].size() == 0) begin
            check("unexpected_rd", i, 32'(exp_q[i].size() + 1), 32'd0);
          end else begin
            e  = exp_q[i].pop_front();
            ec = cyc_q[i].pop_front();
            check("res_ovf", i, 32'({ovf_w[i], res_of(i)}), 32'(e));
            check("latency", i, 32'(cyc), 32'(ec));
          end
        end
        rd_prev[i] = rd_w[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(logic [15:0] a, logic [15:0] b);
    @(negedge CLK);
    ST  = 1'b1;
    IN0 = a;
    IN1 = b;
    for (int i = 0; i < 5; i++) push_one(i, a, b, cyc + 1);
    @(negedge CLK);
    ST  = 1'b0;
    IN0 = 16'($urandom);
    IN1 = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (pending() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 0, 32'(pending()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] da[8] = '{16'h0004, 16'hFFFF, 16'hFFFD, 16'h8000, 16'h0080, 16'h0080, 16'h0000, 16'h8000};
  logic [15:0] db[8] = '{16'h0005, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h0001, 16'h0080, 16'h1234, 16'h0000};

  initial begin
    logic [15:0] a, b;
    RST = 1'b1;
    ST  = 1'b0;
    IN0 = '0;
    IN1 = '0;
    #12;
    for (int i = 0; i < 5; i++)
      check("reset_state", i, 32'({rd_w[i], ovf_w[i], res_of(i)}), 32'd0);
    #3 RST = 1'b0;

    for (int t = 0; t < 8; t++) begin
      start_op(da[t], db[t]);
      wait_drain();
    end

    for (int t = 0; t < 20; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (t % 5 == 0) b = 16'($urandom_range(0, 15));
      if (t % 7 == 0) a = 16'hFFFF - 16'($urandom_range(0, 3));
      start_op(a, b);
      wait_drain();
    end

    // Start re-pulsed while running: must be ignored.
    start_op(16'h0123, 16'h0045);
    repeat (2) @(negedge CLK);
    ST  = 1'b1;
    IN0 = 16'h7777;
    IN1 = 16'h1111;
    @(negedge CLK);
    ST  = 1'b0;
    wait_drain();

    // Start held high for 51 edges: each variant restarts every BW+1 cycles.
    @(negedge CLK);
    a   = 16'h00F3;
    b   = 16'hFF0B;
    ST  = 1'b1;
    IN0 = a;
    IN1 = b;
    for (int j = 0; j < 51; j++) begin
      for (int i = 0; i < 5; i++)
        if (j % (bw_t[i] + 1) == 0) push_one(i, a, b, cyc + 1);
      @(negedge CLK);
    end
    ST = 1'b0;
    wait_drain();

    // Asynchronous reset five cycles into a run.
    start_op(16'h1234, 16'h0042);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("abort_outputs", i, 32'({rd_w[i], ovf_w[i], res_of(i)}), 32'd0);
      void'(exp_q[i].pop_back());
      void'(cyc_q[i].pop_back());
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 5; i++)
      check("idle_after_abort", i, 32'({rd_w[i], ovf_w[i], res_of(i)}), 32'd0);
    start_op(16'd7, 16'd9);
    wait_drain();

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
